posit_accum_raw_es3: RTL and testbench

- Accumulates a stream of raw products from the es3 multiplier stage into one running sum-format value.
- Each product is `{sgn, scale, fraction, inf, zero}`, unrounded.
- Sits directly downstream of the raw multiplier. Its `out_result` uses the sum serialization, so it feeds back as operand 1 of the next multiply or onward to final posit rounding.
- Handshaked input; a one-cycle done pulse marks the end of each accumulation group.

---
 rtl/posit_accum_raw_es3.sv | 251 +++++++++++++++++++++++++
 tb/tb_posit_accum_raw_es3.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_accum_raw_es3.sv
// Accumulates unrounded es3 multiplier products into a running sum-format value.
// Four-cycle ALIGN/ADD/NORM pipeline per product; one-cycle done pulse ends each group.
module posit_accum_raw_es3 #(
    parameter int PBITS  = 54,
    parameter int PSBITS = 10,
    parameter int ABITS  = 30,
    parameter int SSBITS = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [1+PSBITS+PBITS+2-1:0] in_product,
    output logic [1+SSBITS+ABITS+2-1:0] out_result,
    output logic                        out_done
);

    localparam int PW = 1 + PSBITS + PBITS + 2;
    localparam int QW = 1 + PSBITS + ABITS + 2;
    localparam int RW = 1 + SSBITS + ABITS + 2;
    localparam int EW = ABITS + 4;
    localparam int DW = PSBITS + 1;
    localparam int XW = PSBITS + 2;
    localparam int LW = $clog2(EW + 1);

    localparam logic signed [XW-1:0] SC_MAX   = XW'((2 ** (SSBITS - 1)) - 1);
    localparam logic signed [XW-1:0] SC_MIN   = XW'(-(2 ** (SSBITS - 1)));
    localparam logic        [RW-1:0] ZERO_RES = RW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM} state_t;
    typedef enum logic [1:0] {M_ARITH, M_KEEP, M_INF} mode_t;

    state_t               state_q, state_d;
    mode_t                mode_q, mode_d;
    logic [QW-1:0]        prod_q, prod_d;
    logic                 last_q, last_d;
    logic [RW-1:0]        acc_q, acc_d;
    logic                 first_q, first_d;
    logic                 done_q, done_d;
    logic [EW-1:0]        ma_q, ma_d, mp_q, mp_d;
    logic                 sa_q, sa_d, sp_q, sp_d;
    logic signed [XW-1:0] big_q, big_d;
    logic [EW:0]          sum_q, sum_d;
    logic                 sum_sgn_q, sum_sgn_d;

    logic              p_sgn, p_inf, p_zero;
    logic [PSBITS-1:0] p_scale;
    logic [ABITS-1:0]  p_frac;
    logic              a_sgn, a_inf, a_zero;
    logic [SSBITS-1:0] a_scale;
    logic [ABITS-1:0]  a_frac;

    logic              a_eff_zero, a_eff_inf;
    logic [XW-1:0]     a_scale_x, p_scale_x;
    logic [DW-1:0]     scale_diff, diff_mag;
    logic [LW-1:0]     shamt;
    logic [EW-1:0]     ma_full, mp_full;

    logic [EW:0]          sum_add;
    logic                 sgn_add;
    logic [LW-1:0]        lz;
    logic                 lz_found;
    logic [EW-1:0]        norm_m;
    logic signed [XW-1:0] norm_sc;
    logic [RW-1:0]        arith_res, acc_hold;

    assign p_sgn   = prod_q[QW-1];
    assign p_scale = prod_q[QW-2 -: PSBITS];
    assign p_frac  = prod_q[ABITS+1 -: ABITS];
    assign p_inf   = prod_q[1];
    assign p_zero  = prod_q[0];

    assign a_sgn   = acc_q[RW-1];
    assign a_scale = acc_q[RW-2 -: SSBITS];
    assign a_frac  = acc_q[ABITS+1 -: ABITS];
    assign a_inf   = acc_q[1];
    assign a_zero  = acc_q[0];

    assign in_ready   = rst_n & (state_q == S_IDLE);
    assign out_result = acc_q;
    assign out_done   = done_q;

    // A set first flag makes the accumulator read as zero, so a new group needs no clear cycle.
    always_comb begin
        a_eff_zero = first_q | a_zero;
        a_eff_inf  = ~first_q & a_inf;
        a_scale_x  = {{(XW-SSBITS){a_scale[SSBITS-1]}}, a_scale};
        p_scale_x  = {{(XW-PSBITS){p_scale[PSBITS-1]}}, p_scale};
        scale_diff = a_scale_x[DW-1:0] - p_scale_x[DW-1:0];
        diff_mag   = scale_diff[DW-1] ? (DW'(0) - scale_diff) : scale_diff;
        shamt      = (diff_mag > DW'(EW)) ? LW'(EW) : diff_mag[LW-1:0];
        ma_full    = {1'b1, a_frac, 3'b000};
        mp_full    = {1'b1, p_frac, 3'b000};
    end

    always_comb begin
        sum_add = '0;
        sgn_add = 1'b0;
        if (sa_q == sp_q) begin
            sum_add = {1'b0, ma_q} + {1'b0, mp_q};
            sgn_add = sa_q;
        end else if (ma_q > mp_q) begin
            sum_add = {1'b0, ma_q} - {1'b0, mp_q};
            sgn_add = sa_q;
        end else if (mp_q > ma_q) begin
            sum_add = {1'b0, mp_q} - {1'b0, ma_q};
            sgn_add = sp_q;
        end
    end

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int unsigned i = 0; i < EW; i++) begin
            if (!lz_found && sum_q[EW-1-i]) begin
                lz       = LW'(i);
                lz_found = 1'b1;
            end
        end
    end

    always_comb begin
        norm_m    = '0;
        norm_sc   = big_q;
        arith_res = ZERO_RES;
        if (sum_q[EW]) begin
            norm_m  = sum_q[EW:1];
            norm_sc = big_q + XW'(1);
        end else begin
            norm_m  = sum_q[EW-1:0] << lz;
            norm_sc = big_q - XW'(lz);
        end
        if (sum_q == '0) begin
            arith_res = ZERO_RES;
        end else if (norm_sc > SC_MAX) begin
            arith_res = {sum_sgn_q, SC_MAX[SSBITS-1:0], {ABITS{1'b1}}, 2'b00};
        end else if (norm_sc < SC_MIN) begin
            arith_res = ZERO_RES;
        end else begin
            arith_res = {sum_sgn_q, norm_sc[SSBITS-1:0], norm_m[EW-2 -: ABITS], 2'b00};
        end
        acc_hold = first_q ? ZERO_RES : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        prod_d    = prod_q;
        last_d    = last_q;
        acc_d     = acc_q;
        first_d   = first_q;
        done_d    = 1'b0;
        ma_d      = ma_q;
        mp_d      = mp_q;
        sa_d      = sa_q;
        sp_d      = sp_q;
        big_d     = big_q;
        sum_d     = sum_q;
        sum_sgn_d = sum_sgn_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Low product fraction bits are truncated here rather than carried through.
                    prod_d  = {in_product[PW-1 -: 1+PSBITS], in_product[PBITS+1 -: ABITS],
                               in_product[1:0]};
                    last_d  = in_last;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (p_inf | a_eff_inf) begin
                    mode_d = M_INF;
                end else if (p_zero) begin
                    mode_d = M_KEEP;
                end else begin
                    mode_d = M_ARITH;
                end
                sa_d = a_sgn;
                sp_d = p_sgn;
                // Loading into an empty accumulator reuses the add/normalise path with a zero operand.
                if (a_eff_zero) begin
                    ma_d  = '0;
                    mp_d  = mp_full;
                    sa_d  = p_sgn;
                    big_d = p_scale_x;
                end else if (!scale_diff[DW-1]) begin
                    ma_d  = ma_full;
                    mp_d  = mp_full >> shamt;
                    big_d = a_scale_x;
                end else begin
                    ma_d  = ma_full >> shamt;
                    mp_d  = mp_full;
                    big_d = p_scale_x;
                end
                state_d = S_ADD;
            end
            S_ADD: begin
                sum_d     = sum_add;
                sum_sgn_d = sgn_add;
                state_d   = S_NORM;
            end
            S_NORM: begin
                unique case (mode_q)
                    M_INF:   acc_d = {acc_hold[RW-1:2], 2'b10};
                    M_KEEP:  acc_d = acc_hold;
                    default: acc_d = arith_res;
                endcase
                done_d  = last_q;
                first_d = last_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= M_ARITH;
            prod_q    <= '0;
            last_q    <= 1'b0;
            acc_q     <= ZERO_RES;
            first_q   <= 1'b1;
            done_q    <= 1'b0;
            ma_q      <= '0;
            mp_q      <= '0;
            sa_q      <= 1'b0;
            sp_q      <= 1'b0;
            big_q     <= '0;
            sum_q     <= '0;
            sum_sgn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            prod_q    <= prod_d;
            last_q    <= last_d;
            acc_q     <= acc_d;
            first_q   <= first_d;
            done_q    <= done_d;
            ma_q      <= ma_d;
            mp_q      <= mp_d;
            sa_q      <= sa_d;
            sp_q      <= sp_d;
            big_q     <= big_d;
            sum_q     <= sum_d;
            sum_sgn_q <= sum_sgn_d;
        end
    end

endmodule

// File: tb/tb_posit_accum_raw_es3.sv
// Bench for posit_accum_raw_es3: per-cycle comparison against an arithmetic model,
// plus directed groups with hand-computed sum-format results.
module tb_posit_accum_raw_es3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [66:0] in_product = '0;
    logic        in_ready;
    logic        out_done;
    logic [41:0] out_result;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    posit_accum_raw_es3 #(
        .PBITS (54),
        .PSBITS(10),
        .ABITS (30),
        .SSBITS(9)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_product(in_product),
        .out_result(out_result),
        .out_done  (out_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [66:0] mkp(input bit s, input int sc, input logic [53:0] fr,
                                        input bit inf, input bit zr);
        logic [9:0] s10;
        s10 = sc[9:0];
        return {s, s10, fr, inf, zr};
    endfunction

    // Reference: value = +/- (mantissa * 2^(scale-33)) using signed 64-bit integers.
    function automatic logic [41:0] model_acc(input logic [41:0] acc, input bit first,
                                              input logic [66:0] p);
        logic [41:0] a;
        longint am, pm, sum, mag;
        int as_, ps, e, d;
        bit sg;
        logic [8:0] e9;
        logic [29:0] f30;
        a = first ? 42'h1 : acc;
        if (p[1] || a[1]) return {a[41:2], 2'b10};
        if (p[0]) return a;
        ps = int'($signed(p[65:56]));
        pm = (longint'(p[55:26]) + (longint'(1) << 30)) << 3;
        if (a[0]) begin
            mag = pm;
            e   = ps;
            sg  = p[66];
        end else begin
            as_ = int'($signed(a[40:32]));
            am  = (longint'(a[31:2]) + (longint'(1) << 30)) << 3;
            d   = as_ - ps;
            if (d >= 0) begin
                pm = (d >= 34) ? 0 : (pm >> d);
                e  = as_;
            end else begin
                am = (-d >= 34) ? 0 : (am >> (-d));
                e  = ps;
            end
            sum = (a[41] ? -am : am) + (p[66] ? -pm : pm);
            sg  = (sum < 0);
            mag = sg ? -sum : sum;
        end
        if (mag == 0) return 42'h1;
        while (mag >= (longint'(1) << 34)) begin
            mag = mag >> 1;
            e++;
        end
        while (mag < (longint'(1) << 33)) begin
            mag = mag << 1;
            e--;
        end
        if (e > 255) return {sg, 9'h0FF, 30'h3FFF_FFFF, 2'b00};
        if (e < -256) return 42'h1;
        e9  = e[8:0];
        f30 = mag[32:3];
        return {sg, e9, f30, 2'b00};
    endfunction

    initial begin : compare
        int          phase;
        logic [41:0] exp_res;
        bit          exp_done;
        bit          grp_first;
        logic [66:0] cap_p;
        bit          cap_last;
        phase = 0;
        exp_res = 42'h1;
        exp_done = 1'b0;
        grp_first = 1'b1;
        cap_p = '0;
        cap_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0;
                exp_res = 42'h1;
                exp_done = 1'b0;
                grp_first = 1'b1;
                chk("cyc_ready", in_ready, 0);
                chk("cyc_done", out_done, 0);
                chk("cyc_result", out_result, 42'h1);
            end else begin
                chk("cyc_ready", in_ready, (phase == 0));
                chk("cyc_done", out_done, exp_done);
                chk("cyc_result", out_result, exp_res);
                exp_done = 1'b0;
                case (phase)
                    0: begin
                        if (in_valid) begin
                            cap_p = in_product;
                            cap_last = in_last;
                            phase = 1;
                        end
                    end
                    1, 2: phase++;
                    default: begin
                        exp_res = model_acc(exp_res, grp_first, cap_p);
                        grp_first = cap_last;
                        exp_done = cap_last;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    task automatic send(input logic [66:0] p, input bit last);
        int n;
        n = 0;
        in_product = p;
        in_last = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 40) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [41:0] exp);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            @(negedge clk);
            if (out_done) seen = 1'b1;
            else n++;
        end
        if (seen) chk(name, out_result, exp);
        else chk({name, "_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    logic [66:0] one_p, one5_p, quarter_p, neg_one_p, two_p, big_p, tiny_p;
    logic [66:0] inf_p, zero_p, nquarter_p, small_p, infz_p;

    initial begin : stim
        int rc;
        int dc;
        one_p      = mkp(0, 0, '0, 0, 0);
        one5_p     = mkp(0, 0, 54'h1 << 53, 0, 0);
        quarter_p  = mkp(0, -2, '0, 0, 0);
        neg_one_p  = mkp(1, 0, '0, 0, 0);
        two_p      = mkp(0, 1, '0, 0, 0);
        big_p      = mkp(0, 300, '0, 0, 0);
        tiny_p     = mkp(0, -300, '0, 0, 0);
        inf_p      = mkp(0, 0, '0, 1, 0);
        zero_p     = mkp(0, 0, '0, 0, 1);
        nquarter_p = mkp(1, -2, '0, 0, 0);
        small_p    = mkp(0, -40, '0, 0, 0);
        infz_p     = mkp(0, 0, '0, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", out_result, 42'h1);
        chk("reset_ready", in_ready, 0);
        chk("reset_done", out_done, 0);
        rst_n = 1'b1;

        send(one_p, 1);      wait_done("single_one", 42'h0);
        send(one_p, 0);      send(one_p, 1);      wait_done("one_plus_one", 42'h1_0000_0000);
        send(one5_p, 0);     send(quarter_p, 1);  wait_done("one5_plus_quarter", 42'h0_C000_0000);
        send(one_p, 0);      send(neg_one_p, 1);  wait_done("cancel", 42'h1);
        send(two_p, 1);      wait_done("fresh_after_done", 42'h1_0000_0000);
        send(big_p, 1);      wait_done("sat_high", 42'h0FF_FFFF_FFFC);
        send(tiny_p, 1);     wait_done("underflow", 42'h1);
        send(one_p, 0);      send(inf_p, 0);      send(one_p, 1);
        wait_done("inf_mid", 42'h2);
        send(one_p, 0);      send(nquarter_p, 1); wait_done("one_minus_quarter", 42'h1FF_8000_0000);
        send(one_p, 0);      send(zero_p, 1);     wait_done("zero_product", 42'h0);
        send(one_p, 0);      send(small_p, 1);    wait_done("far_shift", 42'h0);
        send(neg_one_p, 1);  wait_done("neg_one", 42'h200_0000_0000);
        send(infz_p, 1);     wait_done("inf_and_zero", 42'h2);

        in_product = one_p;
        in_last = 1'b0;
        in_valid = 1'b1;
        rc = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (in_ready) rc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_ready_count", rc, 4);
        send(one_p, 1);      wait_done("b2b_sum", 42'h2_4000_0000);

        send(one_p, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_result", out_result, 42'h1);
        chk("reset_mid_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_done) dc++;
        end
        chk("reset_no_done", dc, 0);
        @(posedge clk);
        #1;
        send(two_p, 1);      wait_done("after_reset", 42'h1_0000_0000);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
